xgmii_tx_framer: RTL and testbench

- Converts a simple 32-bit packet stream into 32-bit XGMII transmit words (data/ctrl/ena) for the TX side of the 10GBASE-R PCS/PMA chain.
- Inserts Start and preamble/SFD, and emits Terminate with lane alignment from the last-word byte enable.
- Enforces a minimum inter-packet gap (IPG) of idle words.
- Signals input underrun with XGMII error codes, and honours backpressure (rdy) from the PCS.

---
 rtl/xgmii_tx_framer.sv | 182 ++++++++++++++++++
 tb/tb_xgmii_tx_framer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/xgmii_tx_framer.sv
// 32-bit packet stream to XGMII TX framer: Start/preamble insertion, lane-aligned
// Terminate, minimum IPG, underrun abort with Error codes, and PCS backpressure.

module xgmii_tx_lane #(
  parameter int LANE = 0,
  parameter int NW   = 3
) (
  input  logic [7:0]    din,
  input  logic [NW-1:0] n,
  output logic [7:0]    dout,
  output logic          c
);
  always_comb begin
    dout = 8'h07;
    c    = 1'b1;
    if (NW'(LANE) < n) begin
      dout = din;
      c    = 1'b0;
    end else if (NW'(LANE) == n) begin
      dout = 8'hFD;
    end
  end
endmodule

module xgmii_tx_framer #(
  parameter int WIDTH     = 32,
  parameter int IPG_WORDS = 3,
  parameter int CNT_W     = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   s_data,
  input  logic [WIDTH/8-1:0] s_keep,
  input  logic               s_sop,
  input  logic               s_eop,
  input  logic               s_valid,
  output logic               s_ready,
  output logic [WIDTH-1:0]   data,
  output logic [WIDTH/8-1:0] ctrl,
  output logic               ena,
  input  logic               rdy,
  output logic [CNT_W-1:0]   frame_cnt,
  output logic [CNT_W-1:0]   err_cnt
);
  localparam int NL = WIDTH / 8;
  localparam int NW = $clog2(NL + 1);
  localparam int IW = $clog2(IPG_WORDS + 1);

  localparam logic [WIDTH-1:0] W_IDLE  = {NL{8'h07}};
  localparam logic [WIDTH-1:0] W_ERR   = {NL{8'hFE}};
  localparam logic [WIDTH-1:0] W_START = {{(NL-1){8'h55}}, 8'hFB};
  localparam logic [WIDTH-1:0] W_PRE   = {8'hD5, {(NL-1){8'h55}}};
  localparam logic [WIDTH-1:0] W_TERM  = {{(NL-1){8'h07}}, 8'hFD};
  localparam logic [NL-1:0]    C_ALL   = {NL{1'b1}};

  typedef enum logic [2:0] {IDLE, PRE, DATA, TERM, IPG, ERR, DROP} state_t;

  state_t          state, state_n;
  logic [WIDTH-1:0] data_n;
  logic [NL-1:0]    ctrl_n;
  logic [IW-1:0]    ipg_cnt, ipg_n;
  logic             fc_inc, ec_inc, ready_c;
  logic [NW-1:0]    nkeep;

  logic [NL-1:0][7:0] term_d;
  logic [NL-1:0]      term_c;

  always_comb begin
    nkeep = '0;
    for (int i = 0; i < NL; i++) nkeep = nkeep + NW'(s_keep[i]);
  end

  // Partial last word: lanes below popcount(keep) keep data, then FD, then idles.
  for (genvar g = 0; g < NL; g++) begin : g_lane
    xgmii_tx_lane #(.LANE(g), .NW(NW)) u_lane (
      .din  (s_data[8*g +: 8]),
      .n    (nkeep),
      .dout (term_d[g]),
      .c    (term_c[g])
    );
  end

  always_comb begin
    state_n = state;
    data_n  = data;
    ctrl_n  = ctrl;
    ipg_n   = ipg_cnt;
    fc_inc  = 1'b0;
    ec_inc  = 1'b0;
    ready_c = 1'b0;
    if (rdy) begin
      case (state)
        IDLE: begin
          data_n  = W_IDLE;
          ctrl_n  = C_ALL;
          ready_c = !s_sop;
          // The sop word is held until DATA so it is emitted after the preamble.
          if (s_valid && s_sop) begin
            data_n  = W_START;
            ctrl_n  = NL'(1);
            state_n = PRE;
          end
        end
        PRE: begin
          data_n  = W_PRE;
          ctrl_n  = '0;
          state_n = DATA;
        end
        DATA: begin
          ready_c = 1'b1;
          if (!s_valid) begin
            data_n  = W_ERR;
            ctrl_n  = C_ALL;
            ec_inc  = 1'b1;
            state_n = DROP;
          end else if (s_eop && nkeep != NW'(NL)) begin
            data_n  = term_d;
            ctrl_n  = term_c;
            fc_inc  = 1'b1;
            ipg_n   = IW'(IPG_WORDS);
            state_n = IPG;
          end else begin
            data_n = s_data;
            ctrl_n = '0;
            if (s_eop) state_n = TERM;
          end
        end
        TERM: begin
          data_n  = W_TERM;
          ctrl_n  = C_ALL;
          fc_inc  = 1'b1;
          ipg_n   = IW'(IPG_WORDS);
          state_n = IPG;
        end
        IPG: begin
          data_n = W_IDLE;
          ctrl_n = C_ALL;
          ipg_n  = ipg_cnt - IW'(1);
          if (ipg_cnt == IW'(1)) state_n = IDLE;
        end
        DROP: begin
          ready_c = 1'b1;
          data_n  = W_ERR;
          ctrl_n  = C_ALL;
          if (s_valid && s_eop) state_n = ERR;
        end
        ERR: begin
          data_n  = W_TERM;
          ctrl_n  = C_ALL;
          ipg_n   = IW'(IPG_WORDS);
          state_n = IPG;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // ena doubles as "out of reset" so nothing is consumed before the first edge.
  assign s_ready = ready_c & ena;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      data      <= W_IDLE;
      ctrl      <= C_ALL;
      ena       <= 1'b0;
      ipg_cnt   <= '0;
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      ena <= 1'b1;
      if (rdy) begin
        state   <= state_n;
        data    <= data_n;
        ctrl    <= ctrl_n;
        ipg_cnt <= ipg_n;
        if (fc_inc) frame_cnt <= frame_cnt + CNT_W'(1);
        if (ec_inc) err_cnt   <= err_cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_xgmii_tx_framer.sv
// Directed bench for xgmii_tx_framer: reset, full/partial frames, stall, underrun, back-to-back.

module tb_xgmii_tx_framer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_data = '0;
  logic [3:0]  s_keep = 4'hF;
  logic        s_sop = 1'b0, s_eop = 1'b0, s_valid = 1'b0, rdy = 1'b1;
  logic        s_ready, ena;
  logic [31:0] data;
  logic [3:0]  ctrl;
  logic [31:0] frame_cnt, err_cnt;

  int n_chk = 0;
  int n_err = 0;
  logic [35:0] q[$];
  logic [35:0] ex[$];

  xgmii_tx_framer dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_keep(s_keep), .s_sop(s_sop),
    .s_eop(s_eop), .s_valid(s_valid), .s_ready(s_ready), .data(data), .ctrl(ctrl),
    .ena(ena), .rdy(rdy), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Record every output word the PCS actually takes.
  initial begin
    logic r;
    forever begin
      @(posedge clk);
      r = rdy;
      #1;
      if (r && ena) q.push_back({ctrl, data});
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic [3:0] k, input logic sop, input logic eop);
    bit acc = 0;
    s_data = d; s_keep = k; s_sop = sop; s_eop = eop; s_valid = 1'b1;
    for (int t = 0; t < 200 && !acc; t++) begin
      #1;
      acc = s_ready;
      @(negedge clk);
    end
    if (!acc) chk("send timeout", 0, 1);
  endtask

  task automatic idle_in();
    s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0; s_keep = 4'hF;
  endtask

  task automatic cmp(input string tag);
    int s = -1;
    for (int i = 0; i < q.size(); i++)
      if (s < 0 && q[i] == {4'h1, 32'h555555FB}) s = i;
    chk({tag, " start"}, 64'(s >= 0), 1);
    if (s >= 0)
      for (int i = 0; i < ex.size(); i++)
        chk($sformatf("%s w%0d", tag, i), (s + i < q.size()) ? 64'(q[s + i]) : 64'hBAD, 64'(ex[i]));
  endtask

  task automatic ex_hdr();
    ex.delete();
    ex.push_back({4'h1, 32'h555555FB});
    ex.push_back({4'h0, 32'hD5555555});
  endtask

  task automatic ex_idles();
    for (int i = 0; i < 3; i++) ex.push_back({4'hF, 32'h07070707});
  endtask

  initial begin
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst ena", ena, 0);
    chk("rst data", data, 32'h07070707);
    chk("rst ctrl", ctrl, 4'hF);
    chk("rst s_ready", s_ready, 0);
    chk("rst frame_cnt", frame_cnt, 0);
    chk("rst err_cnt", err_cnt, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("post ena", ena, 1);
    chk("post data", data, 32'h07070707);
    chk("post ctrl", ctrl, 4'hF);
    repeat (2) @(negedge clk);

    // 64-byte frame
    q.delete(); ex_hdr();
    for (int i = 0; i < 16; i++) ex.push_back({4'h0, 32'h1000_0000 + i});
    ex.push_back({4'hF, 32'h070707FD}); ex_idles();
    for (int i = 0; i < 16; i++) send(32'h1000_0000 + i, 4'hF, i == 0, i == 15);
    idle_in(); repeat (10) @(negedge clk);
    cmp("f64");
    chk("f64 frame_cnt", frame_cnt, 1);

    // 61-byte frame, upper lanes of last word are junk
    q.delete(); ex_hdr();
    for (int i = 0; i < 15; i++) ex.push_back({4'h0, 32'h2000_0000 + i});
    ex.push_back({4'hE, 32'h0707FDAB}); ex_idles();
    for (int i = 0; i < 15; i++) send(32'h2000_0000 + i, 4'hF, i == 0, 1'b0);
    send(32'hCCCCCCAB, 4'h1, 1'b0, 1'b1);
    idle_in(); repeat (10) @(negedge clk);
    cmp("f61");
    chk("f61 frame_cnt", frame_cnt, 2);

    // backpressure for 5 cycles mid-payload
    q.delete(); ex_hdr();
    for (int i = 0; i < 8; i++) ex.push_back({4'h0, 32'h3000_0000 + i});
    ex.push_back({4'hF, 32'h070707FD}); ex_idles();
    for (int i = 0; i < 4; i++) send(32'h3000_0000 + i, 4'hF, i == 0, 1'b0);
    rdy = 1'b0;
    s_data = 32'h3000_0004; s_sop = 1'b0; s_eop = 1'b0; s_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("stall s_ready", s_ready, 0);
      chk("stall data", data, 32'h3000_0003);
      chk("stall ctrl", ctrl, 4'h0);
      @(negedge clk);
    end
    rdy = 1'b1;
    for (int i = 4; i < 8; i++) send(32'h3000_0000 + i, 4'hF, 1'b0, i == 7);
    idle_in(); repeat (10) @(negedge clk);
    cmp("stall");
    chk("stall frame_cnt", frame_cnt, 3);

    // underrun after payload word 4 of 10
    q.delete(); ex_hdr();
    for (int i = 0; i < 4; i++) ex.push_back({4'h0, 32'h4000_0000 + i});
    for (int i = 0; i < 7; i++) ex.push_back({4'hF, 32'hFEFEFEFE});
    ex.push_back({4'hF, 32'h070707FD}); ex_idles();
    for (int i = 0; i < 4; i++) send(32'h4000_0000 + i, 4'hF, i == 0, 1'b0);
    idle_in(); @(negedge clk);
    chk("urun err_cnt", err_cnt, 1);
    for (int i = 4; i < 10; i++) send(32'h4000_0000 + i, 4'hF, 1'b0, i == 9);
    idle_in(); repeat (10) @(negedge clk);
    cmp("urun");
    chk("urun frame_cnt", frame_cnt, 3);
    chk("urun err_cnt end", err_cnt, 1);

    // back-to-back: second sop waits through the IPG
    q.delete(); ex_hdr();
    ex.push_back({4'h0, 32'h5000_0000}); ex.push_back({4'h0, 32'h5000_0001});
    ex.push_back({4'hF, 32'h070707FD}); ex_idles();
    ex.push_back({4'h1, 32'h555555FB}); ex.push_back({4'h0, 32'hD5555555});
    ex.push_back({4'h0, 32'h6000_0000}); ex.push_back({4'hC, 32'h07FD3344}); ex_idles();
    send(32'h5000_0000, 4'hF, 1'b1, 1'b0);
    send(32'h5000_0001, 4'hF, 1'b0, 1'b1);
    send(32'h6000_0000, 4'hF, 1'b1, 1'b0);
    send(32'h11223344, 4'h3, 1'b0, 1'b1);
    idle_in(); repeat (10) @(negedge clk);
    cmp("b2b");
    chk("b2b frame_cnt", frame_cnt, 5);
    chk("b2b err_cnt", err_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
